// File: rtl/serial_sync_rx.sv
// Serial-to-parallel receiver on the bit clock: hunts for COMMA at any bit offset,
// locks after LOCK_CNT aligned commas, then delivers words until alignment is lost.
module serial_sync_rx #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COMMA    = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'h7C,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             idle_out,
  output logic             active_out,
  output logic             sync_lost
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_t;

  state_t           state, state_d;
  // Only the newest WIDTH-1 bits are kept; the incoming bit completes the window.
  logic [WIDTH-2:0] sr;
  logic [PW-1:0]    ph, ph_d;
  logic [CW-1:0]    comma_cnt, comma_d;
  logic [LW-1:0]    miss_cnt, miss_d;
  logic             miss_flag, mflag_d;
  logic [WIDTH-1:0] window, data_d;
  logic             boundary, is_comma;
  logic             valid_d, idle_d, active_d, lost_d;

  assign window   = {sr, data_in};
  assign boundary = (ph == PH_LAST);
  assign is_comma = (window == COMMA);

  always_comb begin
    state_d  = state;
    ph_d     = boundary ? '0 : ph + PW'(1);
    comma_d  = comma_cnt;
    miss_d   = miss_cnt;
    mflag_d  = miss_flag;
    data_d   = data_out;
    valid_d  = 1'b0;
    idle_d   = idle_out;
    active_d = active_out;
    lost_d   = 1'b0;
    case (state)
      HUNT: begin
        if (is_comma) begin
          ph_d = '0;
          if (LOCK_CNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
            comma_d  = '0;
          end else begin
            state_d = ALIGN;
            comma_d = CW'(1);
          end
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            if (comma_cnt == LOCK_LAST) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
              comma_d  = '0;
            end else if (comma_cnt != '1) begin
              comma_d = comma_cnt + CW'(1);
            end
          end else begin
            // Abort without re-checking this window as a fresh alignment.
            state_d = HUNT;
            comma_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (!boundary) begin
          if (is_comma) mflag_d = 1'b1;
        end else begin
          mflag_d = 1'b0;
          if (is_comma) begin
            idle_d = 1'b0;
          end else if (window == IDLE_SYM) begin
            idle_d = 1'b1;
          end else begin
            data_d  = window;
            valid_d = 1'b1;
            idle_d  = 1'b0;
          end
          // A data word on the losing boundary still goes out with sync_lost.
          if (miss_flag) begin
            if (miss_cnt == LOSS_LAST) begin
              state_d  = HUNT;
              lost_d   = 1'b1;
              active_d = 1'b0;
              idle_d   = 1'b0;
              miss_d   = '0;
            end else if (miss_cnt != '1) begin
              miss_d = miss_cnt + LW'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= HUNT;
      sr         <= '0;
      ph         <= '0;
      comma_cnt  <= '0;
      miss_cnt   <= '0;
      miss_flag  <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      sync_lost  <= 1'b0;
    end else begin
      state      <= state_d;
      sr         <= window[WIDTH-2:0];
      ph         <= ph_d;
      comma_cnt  <= comma_d;
      miss_cnt   <= miss_d;
      miss_flag  <= mflag_d;
      data_out   <= data_d;
      valid_out  <= valid_d;
      idle_out   <= idle_d;
      active_out <= active_d;
      sync_lost  <= lost_d;
    end
  end

endmodule
